// File: rtl/ddc_accum_lanes.sv
// Multi-lane complex DDC: per-lane LO mix, integrate over ACC_LEN samples,
// and dump each frame through a one-deep output register with backpressure.
module ddc_accum_lanes #(
    parameter int N_LANES = 8,
    parameter int DW      = 16,
    parameter int LW      = 16,
    parameter int ACC_LEN = 256,
    localparam int ACC_W  = DW + LW + 1 + $clog2(ACC_LEN)
) (
    input  logic                         clk,
    input  logic                         a_reset,
    input  logic                         s_axis_a_tvalid,
    input  logic [N_LANES*2*DW-1:0]      s_axis_a_tdata,
    input  logic                         s_axis_b_tvalid,
    input  logic [N_LANES*2*LW-1:0]      s_axis_b_tdata,
    input  logic                         acc_restart,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [N_LANES*2*ACC_W-1:0]   m_axis_tdata,
    output logic [15:0]                  frame_cnt,
    output logic                         overflow
);

    localparam int PW = DW + LW;
    localparam int SW = PW + 1;
    localparam int IW = $clog2(ACC_LEN);
    localparam logic [IW-1:0] LAST = IW'(ACC_LEN - 1);

    logic                    p1_v, p1_rst;
    logic signed [DW-1:0]    p1_ar [N_LANES];
    logic signed [DW-1:0]    p1_ai [N_LANES];
    logic signed [LW-1:0]    p1_br [N_LANES];
    logic signed [LW-1:0]    p1_bi [N_LANES];

    logic                    p2_v, p2_rst;
    logic signed [PW-1:0]    p2_ac [N_LANES];
    logic signed [PW-1:0]    p2_bd [N_LANES];
    logic signed [PW-1:0]    p2_ad [N_LANES];
    logic signed [PW-1:0]    p2_bc [N_LANES];

    logic                    p3_v, p3_rst;
    logic signed [SW-1:0]    p3_re [N_LANES];
    logic signed [SW-1:0]    p3_im [N_LANES];

    logic [IW-1:0]           idx;
    logic signed [ACC_W-1:0] acc_re [N_LANES];
    logic signed [ACC_W-1:0] acc_im [N_LANES];
    logic signed [ACC_W-1:0] sum_re [N_LANES];
    logic signed [ACC_W-1:0] sum_im [N_LANES];

    logic accept, first, dump, load, xfer;

    always_comb begin
        accept = s_axis_a_tvalid & s_axis_b_tvalid;
        first  = (idx == '0) || p3_rst;
        dump   = p3_v && !first && (idx == LAST);
        load   = dump && (!m_axis_tvalid || m_axis_tready);
        xfer   = m_axis_tvalid && m_axis_tready;
        for (int i = 0; i < N_LANES; i++) begin
            sum_re[i] = acc_re[i] + ACC_W'(p3_re[i]);
            sum_im[i] = acc_im[i] + ACC_W'(p3_im[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (a_reset) begin
            p1_v   <= 1'b0;
            p1_rst <= 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
                p1_ar[i] <= '0;
                p1_ai[i] <= '0;
                p1_br[i] <= '0;
                p1_bi[i] <= '0;
            end
        end else begin
            p1_v <= accept;
            if (accept) begin
                p1_rst <= acc_restart;
                for (int i = 0; i < N_LANES; i++) begin
                    p1_ar[i] <= s_axis_a_tdata[i*2*DW      +: DW];
                    p1_ai[i] <= s_axis_a_tdata[i*2*DW + DW +: DW];
                    p1_br[i] <= s_axis_b_tdata[i*2*LW      +: LW];
                    p1_bi[i] <= s_axis_b_tdata[i*2*LW + LW +: LW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_reset) begin
            p2_v   <= 1'b0;
            p2_rst <= 1'b0;
            p3_v   <= 1'b0;
            p3_rst <= 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
                p2_ac[i] <= '0;
                p2_bd[i] <= '0;
                p2_ad[i] <= '0;
                p2_bc[i] <= '0;
                p3_re[i] <= '0;
                p3_im[i] <= '0;
            end
        end else begin
            p2_v   <= p1_v;
            p2_rst <= p1_rst;
            p3_v   <= p2_v;
            p3_rst <= p2_rst;
            // Products fit exactly in PW bits, so PW-wide multiply is lossless
            for (int i = 0; i < N_LANES; i++) begin
                p2_ac[i] <= PW'(p1_ar[i]) * PW'(p1_br[i]);
                p2_bd[i] <= PW'(p1_ai[i]) * PW'(p1_bi[i]);
                p2_ad[i] <= PW'(p1_ar[i]) * PW'(p1_bi[i]);
                p2_bc[i] <= PW'(p1_ai[i]) * PW'(p1_br[i]);
                p3_re[i] <= SW'(p2_ac[i]) - SW'(p2_bd[i]);
                p3_im[i] <= SW'(p2_ad[i]) + SW'(p2_bc[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_reset) begin
            idx <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                acc_re[i] <= '0;
                acc_im[i] <= '0;
            end
        end else if (p3_v) begin
            if (first) begin
                idx <= IW'(1);
                for (int i = 0; i < N_LANES; i++) begin
                    acc_re[i] <= ACC_W'(p3_re[i]);
                    acc_im[i] <= ACC_W'(p3_im[i]);
                end
            end else begin
                idx <= (idx == LAST) ? '0 : idx + IW'(1);
                for (int i = 0; i < N_LANES; i++) begin
                    acc_re[i] <= sum_re[i];
                    acc_im[i] <= sum_im[i];
                end
            end
        end
    end

    // A full register with no taker keeps its frame; the new one is lost
    always_ff @(posedge clk) begin
        if (a_reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            frame_cnt     <= '0;
            overflow      <= 1'b0;
        end else begin
            if (load) begin
                m_axis_tvalid <= 1'b1;
                frame_cnt     <= frame_cnt + 16'd1;
                for (int i = 0; i < N_LANES; i++) begin
                    m_axis_tdata[i*2*ACC_W         +: ACC_W] <= sum_re[i];
                    m_axis_tdata[i*2*ACC_W + ACC_W +: ACC_W] <= sum_im[i];
                end
            end else if (xfer) begin
                m_axis_tvalid <= 1'b0;
            end
            if (dump && !load)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddc_accum_lanes.sv
// Directed bench for ddc_accum_lanes: 2 lanes, 16-bit data/LO, 4-sample frames.
module tb_ddc_accum_lanes;

    localparam int N_LANES = 2;
    localparam int DW      = 16;
    localparam int LW      = 16;
    localparam int ACC_LEN = 4;
    localparam int ACC_W   = DW + LW + 1 + $clog2(ACC_LEN);

    logic                       clk = 1'b0;
    logic                       a_reset;
    logic                       s_axis_a_tvalid;
    logic [N_LANES*2*DW-1:0]    s_axis_a_tdata;
    logic                       s_axis_b_tvalid;
    logic [N_LANES*2*LW-1:0]    s_axis_b_tdata;
    logic                       acc_restart;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [N_LANES*2*ACC_W-1:0] m_axis_tdata;
    logic [15:0]                frame_cnt;
    logic                       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    ddc_accum_lanes #(
        .N_LANES(N_LANES), .DW(DW), .LW(LW), .ACC_LEN(ACC_LEN)
    ) dut (
        .clk(clk),
        .a_reset(a_reset),
        .s_axis_a_tvalid(s_axis_a_tvalid),
        .s_axis_a_tdata(s_axis_a_tdata),
        .s_axis_b_tvalid(s_axis_b_tvalid),
        .s_axis_b_tdata(s_axis_b_tdata),
        .acc_restart(acc_restart),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .frame_cnt(frame_cnt),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag,
                     $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lane_val(input int lane, input int im);
        logic [ACC_W-1:0] v;
        v = m_axis_tdata[lane*2*ACC_W + im*ACC_W +: ACC_W];
        return {{(64-ACC_W){v[ACC_W-1]}}, v};
    endfunction

    task automatic set_lane(input int lane, input int xr, input int xi,
                            input int lr, input int li);
        s_axis_a_tdata[lane*2*DW      +: DW] = DW'(xr);
        s_axis_a_tdata[lane*2*DW + DW +: DW] = DW'(xi);
        s_axis_b_tdata[lane*2*LW      +: LW] = LW'(lr);
        s_axis_b_tdata[lane*2*LW + LW +: LW] = LW'(li);
    endtask

    task automatic set_unity();
        set_lane(0, 1, 1, 1, 0);
        set_lane(1, 1, 1, 1, 0);
    endtask

    task automatic set_rot();
        set_lane(0, 3, 2, 0, 1);
        set_lane(1, 1, 0, 5, -7);
    endtask

    task automatic accept_n(input int n);
        s_axis_a_tvalid = 1'b1;
        s_axis_b_tvalid = 1'b1;
        repeat (n) tick();
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
    endtask

    // Called just after the last accepting edge; expects tvalid after 3 edges
    task automatic wait_frame(input string tag);
        int lat;
        lat = 0;
        while (!m_axis_tvalid && lat < 12) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
    endtask

    task automatic check_frame(input string tag, input longint r0,
                               input longint i0, input longint r1,
                               input longint i1);
        check({tag, "_l0_re"}, lane_val(0, 0), r0);
        check({tag, "_l0_im"}, lane_val(0, 1), i0);
        check({tag, "_l1_re"}, lane_val(1, 0), r1);
        check({tag, "_l1_im"}, lane_val(1, 1), i1);
    endtask

    initial begin
        a_reset         = 1'b1;
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        s_axis_a_tdata  = '0;
        s_axis_b_tdata  = '0;
        acc_restart     = 1'b0;
        m_axis_tready   = 1'b1;
        tick();
        tick();
        a_reset = 1'b0;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(|m_axis_tdata), 64'd0);
        check("rst_cnt", 64'(frame_cnt), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

        // Unity LO, exact latency and single-cycle tvalid
        set_unity();
        accept_n(4);
        tick();
        tick();
        check("t1_early", 64'(m_axis_tvalid), 64'd0);
        tick();
        check("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_frame("t1", 4, 4, 4, 4);
        check("t1_cnt", 64'(frame_cnt), 64'd1);
        tick();
        check("t1_pulse", 64'(m_axis_tvalid), 64'd0);

        // Rotation
        set_rot();
        accept_n(4);
        wait_frame("t2");
        check_frame("t2", -8, 12, 20, -28);
        check("t2_cnt", 64'(frame_cnt), 64'd2);
        tick();

        // Extremes: im = 4 * 2 * 2^30 = 2^33
        set_lane(0, -32768, -32768, -32768, -32768);
        set_lane(1, -32768, -32768, -32768, -32768);
        accept_n(4);
        wait_frame("t3");
        check_frame("t3", 0, 64'sd8589934592, 0, 64'sd8589934592);
        check("t3_cnt", 64'(frame_cnt), 64'd3);
        tick();

        // Backpressure: hold frame 1, drop 2 and 3
        m_axis_tready = 1'b0;
        set_unity();
        accept_n(4);
        wait_frame("t4a");
        check("t4_cnt_a", 64'(frame_cnt), 64'd4);
        check("t4_ovf_a", 64'(overflow), 64'd0);
        set_rot();
        accept_n(4);
        repeat (4) tick();
        accept_n(4);
        repeat (4) tick();
        check("t4_held_v", 64'(m_axis_tvalid), 64'd1);
        check_frame("t4_held", 4, 4, 4, 4);
        check("t4_ovf", 64'(overflow), 64'd1);
        check("t4_cnt_b", 64'(frame_cnt), 64'd4);
        // Frame 4 arrives on the same edge the held frame is taken
        accept_n(4);
        tick();
        tick();
        m_axis_tready = 1'b1;
        check("t4_still", 64'(m_axis_tvalid), 64'd1);
        tick();
        check("t4_load_v", 64'(m_axis_tvalid), 64'd1);
        check_frame("t4_new", -8, 12, 20, -28);
        check("t4_cnt_c", 64'(frame_cnt), 64'd5);
        tick();
        check("t4_drain", 64'(m_axis_tvalid), 64'd0);

        // Non-coincident valids ignored
        set_unity();
        s_axis_b_tvalid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            s_axis_a_tvalid = (k % 2 == 0);
            tick();
        end
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        wait_frame("t5a");
        check_frame("t5a", 4, 4, 4, 4);
        check("t5a_cnt", 64'(frame_cnt), 64'd6);
        tick();

        // Restart on the third sample discards the first two
        set_rot();
        accept_n(2);
        set_unity();
        acc_restart = 1'b1;
        accept_n(1);
        acc_restart = 1'b0;
        accept_n(1);
        repeat (3) tick();
        check("t5_no_early", 64'(m_axis_tvalid), 64'd0);
        accept_n(2);
        wait_frame("t5b");
        check_frame("t5b", 4, 4, 4, 4);
        check("t5b_cnt", 64'(frame_cnt), 64'd7);
        tick();

        // Reset with a held frame and a partial frame in flight
        m_axis_tready = 1'b0;
        accept_n(4);
        wait_frame("t6a");
        set_rot();
        accept_n(2);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_tdata", 64'(|m_axis_tdata), 64'd0);
        check("t6_cnt0", 64'(frame_cnt), 64'd0);
        check("t6_ovf", 64'(overflow), 64'd0);
        m_axis_tready = 1'b1;
        set_unity();
        accept_n(4);
        wait_frame("t6b");
        check_frame("t6b", 4, 4, 4, 4);
        check("t6_cnt1", 64'(frame_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
